// File: rtl/fc_params_pkg.sv
// Shared constants and FSM encoding for the FC parameter updater.
//   N_IN/N_OUT : FC layer geometry (inputs per neuron / neurons)
//   DW, FRAC   : signed Q8.8 data word
//   AW         : parameter address width (covers N_TOT entries)
//   N_W        : number of weights; biases start at BIAS_BASE = N_W
//   N_TOT      : total parameter count (weights + biases)
package fc_params_pkg;
    localparam int N_IN      = 196;
    localparam int N_OUT     = 10;
    localparam int DW        = 16;
    localparam int FRAC      = 8;
    localparam int AW        = 11;
    localparam int N_W       = N_IN * N_OUT;
    localparam int N_TOT     = N_W + N_OUT;
    localparam int BIAS_BASE = N_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/fc_weight_updater_if.sv
// Bus bundle between backprop / FC forward layer and the parameter updater.
//   start      : 1-cycle request, accepted in IDLE only; the update buses are
//                sampled on that edge and never again during the pass.
//   weight_upd : flattened dW, element k at [k*DW +: DW]
//   bias_upd   : flattened dB, element i at [i*DW +: DW]
//   init_*     : preload write port, honoured in IDLE only
//   rd_addr    : read address; rd_data returns mem[rd_addr] one cycle later
//   busy/done  : busy high for the whole pass; done pulses once when it ends
//   sat_flag   : sticky clamp indicator
// Protocol: there is no back-pressure. A start pulse is either accepted (IDLE)
// or silently dropped; completion is signalled only by the done pulse.
interface fc_weight_updater_if import fc_params_pkg::*; ;
    logic                  start;
    logic [DW*N_W-1:0]     weight_upd;
    logic [DW*N_OUT-1:0]   bias_upd;
    logic                  init_we;
    logic [AW-1:0]         init_addr;
    logic [DW-1:0]         init_data;
    logic [AW-1:0]         rd_addr;
    logic [DW-1:0]         rd_data;
    logic                  busy;
    logic                  done;
    logic                  sat_flag;

    modport master (
        output start, weight_upd, bias_upd, init_we, init_addr, init_data, rd_addr,
        input  rd_data, busy, done, sat_flag
    );

    modport slave (
        input  start, weight_upd, bias_upd, init_we, init_addr, init_data, rd_addr,
        output rd_data, busy, done, sat_flag
    );
endinterface

// File: rtl/fc_weight_updater_sat_sub.sv
// Combinational saturating subtract: result = sat(a - b).
//   a_i, b_i : signed DW-bit operands
//   result_o : difference clamped to the DW-bit signed range
//   sat_o    : high when the clamp was applied
module sat_sub import fc_params_pkg::*; (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] result_o,
    output logic          sat_o
);
    logic [DW:0] diff;

    always_comb begin
        diff     = {a_i[DW-1], a_i} - {b_i[DW-1], b_i};
        result_o = diff[DW-1:0];
        sat_o    = 1'b0;
        // The top two bits disagree exactly when the true difference falls
        // outside the DW-bit range; the sign bit says which side.
        if (diff[DW] != diff[DW-1]) begin
            sat_o    = 1'b1;
            result_o = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end
endmodule

// File: rtl/fc_weight_updater.sv
// Owner of the trainable FC parameters (10x196 weights + 10 biases).
// A pass applies mem[k] <= sat(mem[k] - upd[k]) for k = 0..N_TOT-1, one
// element per cycle, using a shadow copy of the update buses taken at start.
//   clk, rst    : clock, synchronous active-high reset (clears all parameters)
//   bus         : slave side of fc_weight_updater_if
//   state_dbg_o : current FSM state
module fc_weight_updater import fc_params_pkg::*; (
    input  logic   clk,
    input  logic   rst,
    fc_weight_updater_if.slave bus,
    output state_e state_dbg_o
);
    state_e                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [DW*N_TOT-1:0]    shadow_q, shadow_d;
    logic [DW-1:0]          rd_data_q, rd_data_d;
    logic                   sat_flag_q, sat_flag_d;
    logic [DW-1:0]          mem_q [N_TOT];

    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [DW-1:0]          mem_wdata;
    logic [DW-1:0]          sub_res;
    logic                   sub_sat;

    sat_sub u_sat_sub (
        .a_i      (mem_q[idx_q]),
        .b_i      (shadow_q[int'(idx_q)*DW +: DW]),
        .result_o (sub_res),
        .sat_o    (sub_sat)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (idx_q == AW'(N_TOT - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy    = (state_q == RUN);
        bus.done    = (state_q == DONE);
        state_dbg_o = state_q;
    end

    // Memory write selection: the pass owns the memory while running; the
    // preload port only gets in while idle. A preload in the same cycle as
    // start lands before the pass reads that element.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = sub_res;
        if (state_q == RUN) begin
            mem_we = 1'b1;
        end else if (state_q == IDLE && bus.init_we && bus.init_addr < AW'(N_TOT)) begin
            mem_we    = 1'b1;
            mem_waddr = bus.init_addr;
            mem_wdata = bus.init_data;
        end
    end

    always_comb begin
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        sat_flag_d = sat_flag_q | ((state_q == RUN) && sub_sat);
        rd_data_d  = '0;
        if (bus.rd_addr < AW'(N_TOT)) rd_data_d = mem_q[bus.rd_addr];
        if (state_q == IDLE && bus.start) begin
            idx_d    = '0;
            // Biases sit above the weights so element k is always at k*DW.
            shadow_d = {bus.bias_upd, bus.weight_upd};
        end else if (state_q == RUN) begin
            idx_d = idx_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            shadow_q   <= '0;
            rd_data_q  <= '0;
            sat_flag_q <= 1'b0;
            for (int i = 0; i < N_TOT; i++) mem_q[i] <= '0;
        end else begin
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            rd_data_q  <= rd_data_d;
            sat_flag_q <= sat_flag_d;
            if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        bus.rd_data  = rd_data_q;
        bus.sat_flag = sat_flag_q;
    end
endmodule

// File: tb/tb_fc_weight_updater.sv
// Directed bench for fc_weight_updater. Cycle numbering inside a pass: the
// cycle in which start is high is cycle 0, so done is expected in cycle 1971.
module tb_fc_weight_updater;
    import fc_params_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    state_e state_dbg;

    always #5 clk = ~clk;

    fc_weight_updater_if bus ();

    fc_weight_updater dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    logic [DW-1:0] exp_mem [N_TOT];
    logic [DW-1:0] got_mem [N_TOT];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_bus();
        bus.start      = 1'b0;
        bus.weight_upd = '0;
        bus.bias_upd   = '0;
        bus.init_we    = 1'b0;
        bus.init_addr  = '0;
        bus.init_data  = '0;
        bus.rd_addr    = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_TOT; i++) exp_mem[i] = '0;
    endtask

    task automatic preload(input int addr, input logic [DW-1:0] data);
        bus.init_we   = 1'b1;
        bus.init_addr = AW'(addr);
        bus.init_data = data;
        tick();
        bus.init_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        start_cyc = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    // Returns the cycle (relative to the start cycle) in which done is seen,
    // or -1 if it never appears within the budget.
    task automatic wait_done(output int c);
        c = -1;
        for (int n = 0; n < 3000; n++) begin
            if (bus.done) begin
                c = cyc - start_cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < N_TOT; a++) begin
            bus.rd_addr = AW'(a);
            tick();
            got_mem[a] = bus.rd_data;
        end
    endtask

    function automatic int mem_errors(output int first);
        int n = 0;
        first = -1;
        for (int a = 0; a < N_TOT; a++) begin
            if (got_mem[a] !== exp_mem[a]) begin
                n++;
                if (first < 0) first = a;
            end
        end
        return n;
    endfunction

    task automatic test_reset();
        int n, f;
        clear_bus();
        clear_model();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sat_flag !== 1'b0 || bus.rd_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b sat=%b rd=%h want 0 0 0 0000",
                     bus.busy, bus.done, bus.sat_flag, bus.rd_data);
        end
        total++;
        if (state_dbg !== IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
        end
        rst = 1'b0;
        read_all();
        n = mem_errors(f);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reset_mem: %0d bad, addr %0d got %h want %h", n, f, got_mem[f], exp_mem[f]);
        end
    endtask

    task automatic test_single_update();
        int c, n, f;
        clear_bus();
        preload(5, 16'h0200);
        bus.weight_upd[5*DW +: DW] = 16'h0080;
        pulse_start();
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_busy: got %b want 1", bus.busy);
        end
        wait_done(c);
        total++;
        if (c != 1971 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done_cycle: got cycle %0d busy %b want 1971 busy 0", c, bus.busy);
        end
        tick();
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL single_done_pulse: done still %b want 0", bus.done);
        end
        exp_mem[5] = 16'h0180;
        read_all();
        n = mem_errors(f);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL single_mem: %0d bad, addr %0d got %h want %h", n, f, got_mem[f], exp_mem[f]);
        end
        total++;
        if (bus.sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL single_sat: got %b want 0", bus.sat_flag);
        end
    endtask

    task automatic test_saturation();
        int c, n, f;
        clear_bus();
        preload(0, 16'h7F00);
        bus.weight_upd[0 +: DW]    = 16'h8000;
        bus.bias_upd[9*DW +: DW]   = 16'h0200;
        // Bias preload shares the cycle with start: write first, then pass.
        bus.init_we   = 1'b1;
        bus.init_addr = AW'(1969);
        bus.init_data = 16'h8100;
        pulse_start();
        bus.init_we   = 1'b0;
        wait_done(c);
        total++;
        if (c != 1971) begin
            bad++;
            $display("FAIL sat_done_cycle: got %0d want 1971", c);
        end
        total++;
        if (bus.sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL sat_flag_set: got %b want 1", bus.sat_flag);
        end
        exp_mem[0]    = 16'h7FFF;
        exp_mem[1969] = 16'h8000;
        read_all();
        n = mem_errors(f);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL sat_mem: %0d bad, addr %0d got %h want %h", n, f, got_mem[f], exp_mem[f]);
        end
    endtask

    task automatic test_start_while_busy();
        int c, n, f;
        clear_bus();
        bus.weight_upd[1*DW +: DW] = 16'h0010;
        pulse_start();
        repeat (99) tick();
        bus.weight_upd[1*DW +: DW] = 16'h0100;
        bus.weight_upd[2*DW +: DW] = 16'h0100;
        bus.start     = 1'b1;
        bus.init_we   = 1'b1;
        bus.init_addr = AW'(3);
        bus.init_data = 16'h1234;
        tick();
        bus.start     = 1'b0;
        bus.init_we   = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || state_dbg !== RUN) begin
            bad++;
            $display("FAIL busy_restart: busy=%b state=%0d want 1 %0d", bus.busy, state_dbg, RUN);
        end
        wait_done(c);
        total++;
        if (c != 1971) begin
            bad++;
            $display("FAIL busy_done_cycle: got %0d want 1971", c);
        end
        exp_mem[1] = 16'hFFF0;
        read_all();
        n = mem_errors(f);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL busy_mem: %0d bad, addr %0d got %h want %h", n, f, got_mem[f], exp_mem[f]);
        end
        total++;
        if (bus.sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL sat_sticky: got %b want 1", bus.sat_flag);
        end
    endtask

    task automatic test_reset_mid_pass();
        int c, n, f, n_done;
        clear_bus();
        bus.weight_upd[7*DW +: DW] = 16'h0001;
        pulse_start();
        repeat (499) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || state_dbg !== IDLE || bus.sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: busy=%b state=%0d sat=%b want 0 %0d 0",
                     bus.busy, state_dbg, bus.sat_flag, IDLE);
        end
        n_done = 0;
        repeat (2000) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        total++;
        if (n_done != 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", n_done);
        end
        clear_model();
        read_all();
        n = mem_errors(f);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL abort_mem: %0d bad, addr %0d got %h want %h", n, f, got_mem[f], exp_mem[f]);
        end
        pulse_start();
        wait_done(c);
        total++;
        if (c != 1971) begin
            bad++;
            $display("FAIL abort_rerun_cycle: got %0d want 1971", c);
        end
        exp_mem[7] = 16'hFFFF;
        read_all();
        n = mem_errors(f);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL abort_rerun_mem: %0d bad, addr %0d got %h want %h", n, f, got_mem[f], exp_mem[f]);
        end
    endtask

    task automatic test_back_to_back();
        int c, n, f;
        clear_bus();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        preload(1975, 16'hBEEF);
        bus.bias_upd[3*DW +: DW] = 16'h0010;
        pulse_start();
        wait_done(c);
        total++;
        if (c != 1971) begin
            bad++;
            $display("FAIL b2b_first_cycle: got %0d want 1971", c);
        end
        // Start during DONE must be dropped.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL b2b_done_start: busy=%b state=%0d want 0 %0d", bus.busy, state_dbg, IDLE);
        end
        pulse_start();
        wait_done(c);
        total++;
        if (c != 1971) begin
            bad++;
            $display("FAIL b2b_second_cycle: got %0d want 1971", c);
        end
        exp_mem[1963] = 16'hFFE0;
        read_all();
        n = mem_errors(f);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL b2b_mem: %0d bad, addr %0d got %h want %h", n, f, got_mem[f], exp_mem[f]);
        end
        bus.rd_addr = AW'(1963);
        tick();
        bus.rd_addr = AW'(2000);
        tick();
        total++;
        if (bus.rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL rd_out_of_range: got %h want 0000", bus.rd_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_bus();
        test_reset();
        test_single_update();
        test_saturation();
        test_start_while_busy();
        test_reset_mid_pass();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
